fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 110 +++++++++++
 tb/tb_fifo_rd_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-flag FIFO read port into a valid/ready stream.
// Latency: m_valid two cycles after the first fifo_rd_en; one word per cycle sustained.
// Backpressure: 2-entry output buffer; reads stop while buffered + in-flight words fill it.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t                r_state;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_WIDTH-1:0]  r_xfer_cnt;

  logic                  w_accept;
  logic                  w_arrive;
  logic [1:0]            w_occ;
  logic [2:0]            w_fill;

  // Handshake and slot accounting. The state encoding equals the occupancy.
  // A word accepted this cycle frees its slot before the new read lands, so
  // counting it keeps the pipeline full under continuous m_ready while the
  // buffered + in-flight total still never exceeds two.
  always_comb begin
    w_accept   = m_valid && m_ready;
    w_arrive   = r_inflight;
    w_occ      = r_state;
    w_fill     = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_accept};
    fifo_rd_en = rd_rst_n && !fifo_empty && !flush && (w_fill < 3'd2);
  end

  // Marks a read issued this cycle; its data lands next cycle.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  // Occupancy FSM with head/tail buffer; flush drops buffered and landing words.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_arrive) begin
            r_state <= ST_ONE;
            r_head  <= fifo_rd_data;
          end
        end
        ST_ONE: begin
          if (w_arrive && !w_accept) begin
            r_state <= ST_TWO;
            r_tail  <= fifo_rd_data;
          end else if (w_arrive) begin
            r_head  <= fifo_rd_data;
          end else if (w_accept) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_accept) begin
            r_state <= ST_ONE;
            r_head  <= r_tail;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Accepted-word counter; wraps naturally and survives flush.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_accept) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
    end
  end

  assign m_valid  = (r_state != ST_EMPTY);
  assign m_data   = r_head;
  assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized and directed stimulus with a queue scoreboard.
// The FIFO is modelled as a queue; every word read is expected on the stream in
// order unless a flush or reset discards it before acceptance.
module tb_fifo_rd_stream;

  logic       rd_clk;
  logic       rd_rst_n;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [3:0] fifo_rd_data;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_data;
  logic [3:0] xfer_cnt;

  fifo_rd_stream #(.DATA_WIDTH(4), .CNT_WIDTH(4)) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .xfer_cnt     (xfer_cnt)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int passed = 0;
  int total  = 0;
  int rd_cnt = 0;
  int acc_total = 0;

  logic [3:0] fifo_q[$];
  logic [3:0] exp_q[$];
  logic [3:0] model_cnt;
  logic       had_rd;
  logic [3:0] rd_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive inputs at the falling edge, then play the FIFO side.
  task automatic step(input logic rst_n, input logic fl, input logic rdy);
    @(negedge rd_clk);
    rd_rst_n     = rst_n;
    fifo_rd_data = had_rd ? rd_word : 4'($urandom);
    fifo_empty   = (fifo_q.size() == 0);
    flush        = fl;
    m_ready      = rdy;
    #1;
    had_rd = fifo_rd_en;
    if (fifo_rd_en) begin
      rd_cnt++;
      if (fifo_q.size() == 0) begin
        total++;
        $display("FAIL rd_on_empty: read issued with fifo_empty=%0d", fifo_empty);
      end else begin
        rd_word = fifo_q.pop_front();
        exp_q.push_back(rd_word);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_valid) && n < 200) begin
      step(1'b1, 1'b0, 1'b1);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), n);
    end
  endtask

  // Monitor: compares every accepted word and the counter against the model.
  logic       pstall;
  logic       pflush;
  logic [3:0] pdata;
  initial begin
    pstall = 1'b0;
    pflush = 1'b0;
    pdata  = '0;
    model_cnt = '0;
    forever begin
      @(negedge rd_clk);
      #2;
      if (!rd_rst_n) begin
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        model_cnt = '0;
        pstall = 1'b0;
        pflush = 1'b0;
      end else begin
        chk("xfer_cnt", xfer_cnt, model_cnt);
        if (pflush) chk("valid_after_flush", m_valid, 0);
        if (pstall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, pdata);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL spurious_word: got %0h, expected no word", m_data);
          end else begin
            chk("stream_data", m_data, exp_q.pop_front());
          end
          model_cnt = model_cnt + 4'd1;
          acc_total++;
        end
        if (flush) exp_q.delete();
        pstall = m_valid && !m_ready && !flush;
        pflush = flush;
        pdata  = m_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rd_rst_n = 1'b0;
    fifo_empty = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;
    fifo_rd_data = '0;
    had_rd = 1'b0;
    rd_word = '0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Preloaded 1..8 with m_ready high: 2-cycle latency then 8 back-to-back words.
    rd_cnt = 0;
    for (int v = 1; v <= 8; v++) fifo_q.push_back(4'(v));
    step(1'b1, 1'b0, 1'b1);
    chk("first_rd_en", had_rd, 1);
    step(1'b1, 1'b0, 1'b1);
    chk("latency_n1_valid", m_valid, 0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("burst_valid", m_valid, 1);
    end
    drain();
    chk("burst_reads", rd_cnt, 8);
    chk("burst_xfer_cnt", xfer_cnt, 8);

    // Stalled sink: only two reads fit, head holds 0x3.
    rd_cnt = 0;
    fifo_q.push_back(4'h3); fifo_q.push_back(4'h4); fifo_q.push_back(4'h5);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    chk("stall_reads", rd_cnt, 2);
    chk("stall_head", m_data, 4'h3);
    a0 = acc_total;
    drain();
    chk("stall_delivered", acc_total - a0, 3);

    // Toggling m_ready over 16 words.
    a0 = acc_total;
    for (int v = 0; v < 16; v++) fifo_q.push_back(4'(v ^ 5));
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'(k % 2 == 0));
    drain();
    chk("toggle_delivered", acc_total - a0, 16);

    // Flush with two buffered words and a stalled sink; 0x9 comes out first.
    fifo_q.push_back(4'hA); fifo_q.push_back(4'hB);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("two_valid", m_valid, 1);
    step(1'b1, 1'b1, 1'b0);
    fifo_q.push_back(4'h9);
    step(1'b1, 1'b0, 1'b1);
    chk("flush_valid_next", m_valid, 0);
    a0 = acc_total;
    drain();
    chk("after_flush_words", acc_total - a0, 1);

    // Flush in the cycle after a read issue drops the landing word.
    fifo_q.push_back(4'h7);
    step(1'b1, 1'b0, 1'b0);
    chk("drop_read_issued", had_rd, 1);
    a0 = acc_total;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("drop_valid0", m_valid, 0);
    step(1'b1, 1'b0, 1'b1);
    chk("drop_valid0_b", m_valid, 0);
    fifo_q.push_back(4'h6);
    drain();
    chk("drop_words", acc_total - a0, 1);

    // Counter wrap: 15 accepts then 2 more.
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("wrap_start", xfer_cnt, 0);
    for (int v = 0; v < 15; v++) fifo_q.push_back(4'(v));
    drain();
    chk("wrap_at_f", xfer_cnt, 4'hF);
    fifo_q.push_back(4'hC); fifo_q.push_back(4'hD);
    drain();
    chk("wrap_to_1", xfer_cnt, 4'h1);

    // Reset in the middle of a stream, then a clean restart.
    for (int v = 0; v < 6; v++) fifo_q.push_back(4'(v + 2));
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("post_rst_valid", m_valid, 0);
    a0 = acc_total;
    drain();
    chk("restart_cnt", xfer_cnt, 4'(acc_total - a0));

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 8) fifo_q.push_back(4'($urandom));
      step(1'b1, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
